// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl -- port controller for the gshare PHT (2-bit counters) and
// BTB arrays. Both arrays share one index port. Front-end lookups win the
// port in IDLE, but after STARVE_MAX consecutive lookup grants with an update
// pending, the queued update takes the port. An update is a 3-cycle
// read-modify-write: issue the read, wait for the data, write it back.
//
// Optional feature macro: BP_INIT_CLEAR_EN. When defined, reset enters INIT
// and both arrays are zeroed before init_done rises. When undefined, reset
// enters IDLE and init_done is tied high.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   lk_valid/lk_idx     lookup request and index
//   lk_grant            lookup owns the port this cycle (combinational)
//   up_valid/up_ready   update push handshake into the FIFO
//   up_idx/up_taken     counter index and resolved direction
//   up_btb_wr/up_tag/up_target   optional BTB write payload
//   tbl_idx             shared array index
//   pht_rd/pht_rdata    PHT read strobe, data one cycle later
//   pht_we/pht_wdata    PHT write
//   btb_we/btb_wdata    BTB write, {valid, tag[24:0], target[31:0]}
//   init_done           arrays usable
module bp_update_ctrl #(
  parameter int IDX_W      = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_grant,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_taken,
  input  logic             up_btb_wr,
  input  logic [24:0]      up_tag,
  input  logic [31:0]      up_target,
  output logic [IDX_W-1:0] tbl_idx,
  output logic             pht_rd,
  input  logic [1:0]       pht_rdata,
  output logic             pht_we,
  output logic [1:0]       pht_wdata,
  output logic             btb_we,
  output logic [57:0]      btb_wdata,
  output logic             init_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {INIT, IDLE, UPD_RD, UPD_WR} state_t;

`ifdef BP_INIT_CLEAR_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, state_nx;

  // Update FIFO storage
  logic [IDX_W-1:0] f_idx    [FIFO_DEPTH];
  logic             f_taken  [FIFO_DEPTH];
  logic             f_btb_wr [FIFO_DEPTH];
  logic [24:0]      f_tag    [FIFO_DEPTH];
  logic [31:0]      f_target [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;

  logic fifo_ne, fifo_full, push, pop, lk_take, upd_issue, starve_hit;

  logic [IDX_W-1:0] head_idx;
  logic             head_taken, head_btb_wr;
  logic [24:0]      head_tag;
  logic [31:0]      head_target;

  assign fifo_ne    = (count != '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign up_ready   = init_done && !fifo_full && !rst;
  assign push       = up_valid && up_ready;
  assign starve_hit = fifo_ne && (starve_cnt == SC_W'(STARVE_MAX));

  assign head_idx    = f_idx[rd_ptr];
  assign head_taken  = f_taken[rd_ptr];
  assign head_btb_wr = f_btb_wr[rd_ptr];
  assign head_tag    = f_tag[rd_ptr];
  assign head_target = f_target[rd_ptr];

`ifdef BP_INIT_CLEAR_EN
  logic [IDX_W-1:0] init_idx;
  logic             init_done_q;
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  // Port arbitration and array strobes. Everything is forced to its idle
  // value while rst is high so an interrupted UPD_WR never writes.
  always_comb begin
    state_nx  = state;
    lk_take   = 1'b0;
    upd_issue = 1'b0;
    pop       = 1'b0;
    lk_grant  = 1'b0;
    pht_rd    = 1'b0;
    pht_we    = 1'b0;
    pht_wdata = '0;
    btb_we    = 1'b0;
    btb_wdata = '0;
    tbl_idx   = '0;
    if (!rst) begin
      case (state)
        INIT: begin
`ifdef BP_INIT_CLEAR_EN
          tbl_idx = init_idx;
          pht_we  = 1'b1;
          btb_we  = 1'b1;
          if (init_idx == '1) state_nx = IDLE;
`else
          state_nx = IDLE;
`endif
        end
        IDLE: begin
          if (lk_valid && !starve_hit) begin
            lk_take  = 1'b1;
            lk_grant = 1'b1;
            pht_rd   = 1'b1;
            tbl_idx  = lk_idx;
          end else if (fifo_ne) begin
            upd_issue = 1'b1;
            pht_rd    = 1'b1;
            tbl_idx   = head_idx;
            state_nx  = UPD_RD;
          end
        end
        UPD_RD: begin
          tbl_idx  = head_idx;
          state_nx = UPD_WR;
        end
        UPD_WR: begin
          tbl_idx = head_idx;
          pht_we  = 1'b1;
          if (head_taken)
            pht_wdata = (pht_rdata == 2'b11) ? 2'b11 : pht_rdata + 2'b01;
          else
            pht_wdata = (pht_rdata == 2'b00) ? 2'b00 : pht_rdata - 2'b01;
          if (head_btb_wr) begin
            btb_we    = 1'b1;
            btb_wdata = {1'b1, head_tag, head_target};
          end
          pop      = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = RST_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_STATE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // Counts lookup wins only while an update is waiting; the update
      // issue (or an empty FIFO) restarts the budget.
      if (!fifo_ne)
        starve_cnt <= '0;
      else if (lk_take)
        starve_cnt <= starve_cnt + SC_W'(1);
      else if (upd_issue)
        starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_idx[wr_ptr]    <= up_idx;
      f_taken[wr_ptr]  <= up_taken;
      f_btb_wr[wr_ptr] <= up_btb_wr;
      f_tag[wr_ptr]    <= up_tag;
      f_target[wr_ptr] <= up_target;
    end
  end

`ifdef BP_INIT_CLEAR_EN
  // init_idx wraps back to 0 on the same edge that leaves INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx    <= '0;
      init_done_q <= 1'b0;
    end else if (state == INIT) begin
      init_idx <= init_idx + IDX_W'(1);
      if (init_idx == '1) init_done_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Testbench for bp_update_ctrl: randomized and directed traffic, a scoreboard
// of accepted updates, and a PHT reference array holding committed counters.
module tb_bp_update_ctrl;

  localparam int IDX_W = 7;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;
  localparam int N_ENT = 1 << IDX_W;

`ifdef BP_INIT_CLEAR_EN
  localparam bit INIT_DEFAULT = 1'b0;
`else
  localparam bit INIT_DEFAULT = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             lk_valid;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_grant;
  logic             up_valid;
  logic             up_ready;
  logic [IDX_W-1:0] up_idx;
  logic             up_taken;
  logic             up_btb_wr;
  logic [24:0]      up_tag;
  logic [31:0]      up_target;
  logic [IDX_W-1:0] tbl_idx;
  logic             pht_rd;
  logic [1:0]       pht_rdata;
  logic             pht_we;
  logic [1:0]       pht_wdata;
  logic             btb_we;
  logic [57:0]      btb_wdata;
  logic             init_done;

  bp_update_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_grant(lk_grant),
    .up_valid(up_valid), .up_ready(up_ready), .up_idx(up_idx),
    .up_taken(up_taken), .up_btb_wr(up_btb_wr), .up_tag(up_tag),
    .up_target(up_target), .tbl_idx(tbl_idx), .pht_rd(pht_rd),
    .pht_rdata(pht_rdata), .pht_we(pht_we), .pht_wdata(pht_wdata),
    .btb_we(btb_we), .btb_wdata(btb_wdata), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic             btb_wr;
    logic [24:0]      tag;
    logic [31:0]      target;
    int unsigned      push_cyc;
  } req_t;

  req_t        sb[$];
  logic [1:0]  pht_mem [N_ENT];
  logic [1:0]  model   [N_ENT];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_wr_cyc = 0;
  int unsigned last_lat = 0;
  logic [1:0]  last_wdata;
  int unsigned n_writes = 0;
  int unsigned init_cnt = 0;
  int unsigned streak   = 0;
  bit          tb_init_done = INIT_DEFAULT;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Array model the DUT drives: synchronous read data, synchronous write.
  always @(posedge clk) begin
    if (pht_we) pht_mem[tbl_idx] <= pht_wdata;
    if (pht_rd) pht_rdata <= pht_mem[tbl_idx];
  end

  // Stimulus side of the scoreboard: every accepted push is queued.
  always @(posedge clk) begin
    if (rst) sb.delete();
    else if (up_valid && up_ready)
      sb.push_back('{idx: up_idx, taken: up_taken, btb_wr: up_btb_wr,
                     tag: up_tag, target: up_target, push_cyc: cyc});
    cyc++;
  end

  // Monitor: sampled mid-cycle, compares DUT activity with the reference.
  always @(negedge clk) begin
    if (rst) begin
      tb_init_done = INIT_DEFAULT;
      init_cnt     = 0;
      streak       = 0;
    end else begin
      check("init_done", init_done, tb_init_done);
      check("up_ready", up_ready, tb_init_done && (sb.size() < DEPTH));
      if (!tb_init_done) begin
        check("init_pht_we", pht_we, 1);
        check("init_btb_we", btb_we, 1);
        check("init_idx", tbl_idx, init_cnt);
        check("init_pht_wdata", pht_wdata, 0);
        check("init_btb_wdata", btb_wdata, 0);
        check("init_no_grant", lk_grant, 0);
        model[init_cnt] = 2'd0;
        init_cnt++;
        if (init_cnt == N_ENT) tb_init_done = 1'b1;
      end else begin
        if (lk_grant) begin
          check("grant_lk_valid", lk_valid, 1);
          check("grant_idx", tbl_idx, lk_idx);
          check("grant_rd", pht_rd, 1);
          check("grant_no_we", pht_we, 0);
        end
        if (lk_valid && sb.size() == 0) check("free_grant", lk_grant, 1);
        if (lk_grant && sb.size() > 0) begin
          streak++;
          check("starve_bound", streak <= SMAX, 1);
        end else streak = 0;
        if (pht_we) begin
          if (sb.size() == 0) check("spurious_write", pht_we, 0);
          else begin
            req_t r;
            logic [1:0] c, nxt;
            int unsigned start;
            r = sb.pop_front();
            c = model[r.idx];
            if (r.taken) nxt = (c == 2'd3) ? 2'd3 : c + 2'd1;
            else         nxt = (c == 2'd0) ? 2'd0 : c - 2'd1;
            model[r.idx] = nxt;
            check("wr_idx", tbl_idx, r.idx);
            check("wr_pht_wdata", pht_wdata, nxt);
            check("wr_btb_we", btb_we, r.btb_wr);
            if (r.btb_wr) check("wr_btb_wdata", btb_wdata, {1'b1, r.tag, r.target});
            check("wr_min_latency", (cyc - r.push_cyc) >= 3, 1);
            start = (r.push_cyc > last_wr_cyc) ? r.push_cyc : last_wr_cyc;
            check("wr_max_latency", (cyc - start) <= SMAX + 3, 1);
            last_lat    = cyc - r.push_cyc;
            last_wdata  = pht_wdata;
            last_wr_cyc = cyc;
            n_writes++;
          end
        end else if (btb_we) check("btb_we_alone", btb_we, 0);
      end
    end
  end

  task automatic rand_req();
    up_idx    = IDX_W'($urandom);
    up_taken  = 1'($urandom);
    up_btb_wr = 1'($urandom);
    up_tag    = 25'($urandom);
    up_target = $urandom;
  endtask

  // Hold up_valid until accepted; returns just after the accepting edge.
  task automatic push(input logic [IDX_W-1:0] idx, input logic t, input logic b,
                      input logic [24:0] tag, input logic [31:0] tgt);
    up_valid = 1'b1; up_idx = idx; up_taken = t; up_btb_wr = b;
    up_tag = tag; up_target = tgt;
    @(negedge clk);
    for (int k = 0; k < 50 && !up_ready; k++) @(negedge clk);
    if (!up_ready) check("push_timeout", up_ready, 1);
    @(posedge clk); #1;
    up_valid = 1'b0;
  endtask

  task automatic wait_writes(input int unsigned target, input string name);
    for (int k = 0; k < 200 && n_writes < target; k++) @(negedge clk);
    check(name, n_writes >= target, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  task automatic wait_init();
    for (int k = 0; k < 300 && !init_done; k++) @(negedge clk);
    check("wait_init_done", init_done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned grants, stall, nw;
    for (int i = 0; i < N_ENT; i++) begin
      pht_mem[i] = 2'($urandom);
      model[i]   = pht_mem[i];
    end
    pht_rdata = '0;
    rst = 1'b1; lk_valid = 1'b1; lk_idx = 7'h2A; up_valid = 1'b1;
    rand_req();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lk_grant", lk_grant, 0);
    check("rst_pht_rd", pht_rd, 0);
    check("rst_pht_we", pht_we, 0);
    check("rst_btb_we", btb_we, 0);
    check("rst_pht_wdata", pht_wdata, 0);
    check("rst_btb_wdata", btb_wdata, 0);
    check("rst_tbl_idx", tbl_idx, 0);
    check("rst_up_ready", up_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; lk_valid = 1'b0; up_valid = 1'b0;
    wait_init();

    // Single update, with the exact 3-cycle push-to-write latency.
    pht_mem[5] = 2'd1; model[5] = 2'd1;
    nw = n_writes;
    push(7'd5, 1'b1, 1'b1, 25'h1ABCDEF, 32'h400);
    wait_writes(nw + 1, "single_write_seen");
    check("single_latency", last_lat, 3);
    check("single_wdata", last_wdata, 2);

    // Counter saturation at both ends.
    @(posedge clk); #1;
    pht_mem[9] = 2'd3; model[9] = 2'd3;
    push(7'd9, 1'b1, 1'b0, 25'h0, 32'h0);
    wait_writes(nw + 2, "sat_hi_seen");
    check("sat_hi_wdata", last_wdata, 3);
    @(posedge clk); #1;
    pht_mem[9] = 2'd0; model[9] = 2'd0;
    push(7'd9, 1'b0, 1'b0, 25'h0, 32'h0);
    wait_writes(nw + 3, "sat_lo_seen");
    check("sat_lo_wdata", last_wdata, 0);

    // Starvation: lookups held high, one update pending.
    @(posedge clk); #1;
    lk_valid = 1'b1; lk_idx = 7'h33;
    push(7'd20, 1'b1, 1'b1, 25'h155, 32'hCAFE);
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lk_grant) grants++; else break;
    end
    check("starve_grants", grants, SMAX);
    stall = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!lk_grant) stall++; else break;
    end
    check("starve_stall", stall, 3);

    // Full FIFO with lookups hogging the port.
    wait_drain("pre_full_drain");
    @(posedge clk); #1;
    up_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_req();
      @(negedge clk);
      check("full_fill_ready", up_ready, 1);
      @(posedge clk); #1;
    end
    up_valid = 1'b0;
    @(negedge clk);
    check("full_not_ready", up_ready, 0);
    for (int k = 0; k < 20 && !pht_we; k++) @(negedge clk);
    check("full_pop_seen", pht_we, 1);
    check("full_ready_at_pop", up_ready, 0);
    @(negedge clk);
    check("full_ready_after_pop", up_ready, 1);
    lk_valid = 1'b0;
    wait_drain("full_drain");

    // Reset during UPD_RD with three entries queued.
    @(posedge clk); #1;
    up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req();
      @(posedge clk); #1;
    end
    up_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pht_rd && !lk_grant) break;
    end
    check("mid_issue_seen", pht_rd && !lk_grant, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid_rst_pht_we", pht_we, 0);
      check("mid_rst_btb_we", btb_we, 0);
      check("mid_rst_up_ready", up_ready, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    wait_init();
    nw = n_writes;
    repeat (10) @(negedge clk);
    check("mid_rst_empty_ready", up_ready, 1);
    check("mid_rst_no_writes", n_writes, nw);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      lk_valid = 1'($urandom);
      lk_idx   = IDX_W'($urandom);
      up_valid = ($urandom_range(0, 2) == 0);
      rand_req();
      @(posedge clk); #1;
    end
    lk_valid = 1'b0; up_valid = 1'b0;
    wait_drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
